// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps through a small program table and issues opcode/operand pairs to an ALU
// over a valid/ready handshake. Define ALU_SEQ_REPEAT_EN to add a per-entry repeat count.
module alu_op_sequencer #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [3:0]  wr_opcode_i,
  input  logic [15:0] wr_operand_i,
  input  logic [3:0]  wr_repeat_i,
  input  logic [3:0]  last_addr_i,
  input  logic        start_i,
  input  logic        ready_i,
  output logic [3:0]  opcode_o,
  output logic [15:0] operand_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o
);

  // state | meaning
  // IDLE  | waiting for start_i, table writable, outputs parked on pass-through
  // ISSUE | presenting entry[pc] until the ALU accepts it
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] OP_PASS = 4'hC;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  last_q, last_d;
  logic [3:0]     rep_q, rep_d;
  logic [3:0]     opcode_q, opcode_d;
  logic [15:0]    operand_q, operand_d;

  logic [AW-1:0]  pc_nxt;
  logic [AW-1:0]  last_clamp;
  logic [AW-1:0]  wr_idx;
  logic           wr_ok;
  logic [3:0]     rep_first;
  logic [3:0]     rep_next;

  logic [3:0]     tbl_op_q  [DEPTH];
  logic [15:0]    tbl_opd_q [DEPTH];

  // Upper address bits are deliberately ignored when the table is smaller than 16 entries.
  logic           unused_addr;
  assign unused_addr = ^wr_addr_i;

  assign wr_ok  = wr_en_i && (state_q == IDLE);
  assign wr_idx = wr_addr_i[AW-1:0];
  assign pc_nxt = pc_q + AW'(1);

  assign last_clamp = (5'(last_addr_i) > 5'(DEPTH - 1)) ? AW'(DEPTH - 1)
                                                        : last_addr_i[AW-1:0];

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      tbl_op_q[wr_idx]  <= wr_opcode_i;
      tbl_opd_q[wr_idx] <= wr_operand_i;
    end
  end

`ifdef ALU_SEQ_REPEAT_EN
  logic [3:0] tbl_rep_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      tbl_rep_q[wr_idx] <= wr_repeat_i;
    end
  end

  assign rep_first = tbl_rep_q[0];
  assign rep_next  = tbl_rep_q[pc_nxt];
`else
  logic unused_repeat;
  assign unused_repeat = ^wr_repeat_i;
  assign rep_first     = 4'd0;
  assign rep_next      = 4'd0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      rep_q     <= '0;
      opcode_q  <= OP_PASS;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      rep_q     <= rep_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_d    = last_q;
    rep_d     = rep_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;

    unique case (state_q)
      IDLE: begin
        opcode_d  = OP_PASS;
        operand_d = '0;
        if (start_i) begin
          last_d    = last_clamp;
          pc_d      = '0;
          rep_d     = rep_first;
          opcode_d  = tbl_op_q[0];
          operand_d = tbl_opd_q[0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (ready_i) begin
          if (rep_q != 4'd0) begin
            rep_d = rep_q - 4'd1;
          end else if (pc_q != last_q) begin
            // Preload the next entry so outputs stay registered across the step.
            pc_d      = pc_nxt;
            rep_d     = rep_next;
            opcode_d  = tbl_op_q[pc_nxt];
            operand_d = tbl_opd_q[pc_nxt];
          end else begin
            opcode_d  = OP_PASS;
            operand_d = '0;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        opcode_d  = OP_PASS;
        operand_d = '0;
        state_d   = IDLE;
      end
      default: begin
        opcode_d  = OP_PASS;
        operand_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;
  assign valid_o   = (state_q == ISSUE);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a DEPTH=16 instance plus a DEPTH=4 instance sharing stimulus.
// Expected issue sequences follow ALU_SEQ_REPEAT_EN the same way the design build does.
module tb_alu_op_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic        wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [3:0]  wr_opcode_i;
  logic [15:0] wr_operand_i;
  logic [3:0]  wr_repeat_i;
  logic [3:0]  last_addr_i;
  logic        start_i;
  logic        ready_i;
  logic [3:0]  opcode_o;
  logic [15:0] operand_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  opcode4;
  logic [15:0] operand4;
  logic        valid4;
  logic        busy4;
  logic        done4;

  alu_op_sequencer #(.DEPTH(16)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_opcode_i(wr_opcode_i), .wr_operand_i(wr_operand_i), .wr_repeat_i(wr_repeat_i),
    .last_addr_i(last_addr_i), .start_i(start_i), .ready_i(ready_i),
    .opcode_o(opcode_o), .operand_o(operand_o), .valid_o(valid_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  alu_op_sequencer #(.DEPTH(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_opcode_i(wr_opcode_i), .wr_operand_i(wr_operand_i), .wr_repeat_i(wr_repeat_i),
    .last_addr_i(last_addr_i), .start_i(start_i), .ready_i(ready_i),
    .opcode_o(opcode4), .operand_o(operand4), .valid_o(valid4), .busy_o(busy4),
    .done_o(done4)
  );

`ifdef ALU_SEQ_REPEAT_EN
  localparam int N_BASE = 5;
`else
  localparam int N_BASE = 3;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          start_cyc;
  int          done_cyc;
  int          done_cnt;
  int          done4_cnt;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_word;

  logic [19:0] act_q[$];
  logic [19:0] act4_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] exp4_q[$];
  logic [19:0] tmp_q[$];
  logic [19:0] cmp_a[$];
  logic [19:0] cmp_e[$];
  logic [19:0] base_q[$];

  logic [3:0]  mdl_op  [16];
  logic [15:0] mdl_opd [16];
  logic [3:0]  mdl_rep [16];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observes handshakes at the falling edge; inputs only change 2 time units after the rising edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (prev_stall)
        check_eq("hold", {11'd0, valid_o, opcode_o, operand_o}, {11'd0, 1'b1, prev_word});
      if (valid_o && ready_i) act_q.push_back({opcode_o, operand_o});
      if (valid4 && ready_i) act4_q.push_back({opcode4, operand4});
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done4) done4_cnt++;
      prev_stall = valid_o && !ready_i;
      prev_word  = {opcode_o, operand_o};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input int addr, input logic [3:0] op, input logic [15:0] opd, input logic [3:0] rep);
    wr_en_i      = 1'b1;
    wr_addr_i    = 4'(addr);
    wr_opcode_i  = op;
    wr_operand_i = opd;
    wr_repeat_i  = rep;
    step();
    wr_en_i = 1'b0;
    mdl_op[addr]  = op;
    mdl_opd[addr] = opd;
    mdl_rep[addr] = rep;
  endtask

  function automatic void build_exp(input int last, input int depth);
    int l;
    int n;
    l = (last >= depth) ? depth - 1 : last;
    tmp_q.delete();
    for (int i = 0; i <= l; i++) begin
`ifdef ALU_SEQ_REPEAT_EN
      n = int'(mdl_rep[i]);
`else
      n = 0;
`endif
      for (int r = 0; r <= n; r++) tmp_q.push_back({mdl_op[i], mdl_opd[i]});
    end
  endfunction

  task automatic cmp_seq(input string tag);
    check_eq({tag, "_len"}, cmp_a.size(), cmp_e.size());
    for (int i = 0; i < cmp_e.size() && i < cmp_a.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), {12'd0, cmp_a[i]}, {12'd0, cmp_e[i]});
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0...
  // disturb: write entry 0 and hold start_i high while the program is running.
  task automatic run(input logic [3:0] last, input int mode, input bit disturb, input string tag);
    act_q.delete();
    act4_q.delete();
    done_cnt  = 0;
    done4_cnt = 0;
    last_addr_i = last;
    ready_i     = 1'b1;
    start_i     = 1'b1;
    step();
    start_i   = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 200; k++) begin
      ready_i = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      if (disturb && k == 1) begin
        wr_en_i      = 1'b1;
        wr_addr_i    = 4'd0;
        wr_opcode_i  = 4'h5;
        wr_operand_i = 16'hBEEF;
        wr_repeat_i  = 4'd1;
      end
      start_i = disturb && (k >= 2);
      step();
      wr_en_i = 1'b0;
      if (done_cnt != 0 && done4_cnt != 0) break;
    end
    start_i = 1'b0;
    check_eq({tag, "_finished"}, (done_cnt != 0 && done4_cnt != 0), 1);
    ready_i = 1'b1;
    step();
    step();
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_idle_after"}, {valid_o, busy_o, opcode_o}, {2'b00, 4'hC});
  endtask

  initial begin
    rst_ni       = 1'b0;
    wr_en_i      = 1'b0;
    wr_addr_i    = '0;
    wr_opcode_i  = '0;
    wr_operand_i = '0;
    wr_repeat_i  = '0;
    last_addr_i  = '0;
    start_i      = 1'b0;
    ready_i      = 1'b1;
    done_cnt     = 0;
    done4_cnt    = 0;

`ifdef ALU_SEQ_REPEAT_EN
    base_q = '{20'h01234, 20'h30000, 20'h30000, 20'h30000, 20'hE0000};
`else
    base_q = '{20'h01234, 20'h30000, 20'hE0000};
`endif

    repeat (3) @(posedge clk_i);
    #2;
    check_eq("rst_outputs", {valid_o, busy_o, done_o, opcode_o, operand_o},
             {3'b000, 4'hC, 16'h0000});
    rst_ni = 1'b1;
    step();
    check_eq("idle_outputs", {valid_o, busy_o, done_o, opcode_o, operand_o},
             {3'b000, 4'hC, 16'h0000});

    wr(0, 4'h0, 16'h1234, 4'd0);
    wr(1, 4'h3, 16'h0000, 4'd2);
    wr(2, 4'hE, 16'h0000, 4'd0);

    // Basic program with ready held high.
    run(4'd2, 0, 1'b0, "basic");
    cmp_a = act_q; cmp_e = base_q; cmp_seq("basic_seq");
    check_eq("basic_done_lat", done_cyc - start_cyc, N_BASE);

    // Same program, ready toggling; the negedge monitor checks hold-while-stalled.
    run(4'd2, 1, 1'b0, "toggle");
    cmp_a = act_q; cmp_e = base_q; cmp_seq("toggle_seq");

    // Reset during the second issue of entry 1 (entry 2 when repeats are compiled out).
    last_addr_i = 4'd2;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
`ifdef ALU_SEQ_REPEAT_EN
    check_eq("pre_rst_word", {valid_o, opcode_o}, {1'b1, 4'h3});
`else
    check_eq("pre_rst_word", {valid_o, opcode_o}, {1'b1, 4'hE});
`endif
    rst_ni = 1'b0;
    #1;
    check_eq("rst_mid_run", {valid_o, busy_o, done_o, opcode_o, operand_o},
             {3'b000, 4'hC, 16'h0000});
    step();
    rst_ni = 1'b1;
    step();
    step();
    check_eq("no_resume", {valid_o, busy_o}, 2'b00);
    run(4'd2, 0, 1'b0, "rerun");
    cmp_a = act_q; cmp_e = base_q; cmp_seq("rerun_seq");

    // Write and start while busy are both dropped.
    run(4'd2, 0, 1'b1, "busy_wr");
    cmp_a = act_q; cmp_e = base_q; cmp_seq("busy_wr_seq");
    run(4'd2, 0, 1'b0, "old_e0");
    cmp_a = act_q; cmp_e = base_q; cmp_seq("old_e0_seq");

    // Idle write does take effect.
    wr(0, 4'h5, 16'hBEEF, 4'd1);
    run(4'd2, 0, 1'b0, "new_e0");
    build_exp(2, 16);
    cmp_a = act_q; cmp_e = tmp_q; cmp_seq("new_e0_seq");
    check_eq("new_e0_first", {12'd0, act_q.size() > 0 ? act_q[0] : 20'h0}, {12'd0, 20'h5BEEF});

    // last_addr_i beyond the table: the DEPTH=4 instance stops after entry 3.
    for (int a = 4; a < 16; a++) wr(a, 4'(a), 16'(16'h1000 + a), 4'd0);
    for (int a = 0; a < 4; a++) wr(a, 4'(8 + a), 16'(16'hA000 + a), (a == 1) ? 4'd1 : 4'd0);
    run(4'd15, 0, 1'b0, "clamp");
    build_exp(15, 4);
    exp4_q = tmp_q;
    cmp_a = act4_q; cmp_e = exp4_q; cmp_seq("clamp4_seq");
    check_eq("clamp4_done", done4_cnt, 1);
    build_exp(15, 16);
    exp_q = tmp_q;
    cmp_a = act_q; cmp_e = exp_q; cmp_seq("full16_seq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
